ex_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer attached to the EX stage of the five-stage pipeline; it executes MULT, MULTU, DIV and DIVU iteratively and owns the HI/LO registers.
- Stalls the upstream pipeline while an operation runs, then writes HI/LO atomically.
- Also services MTHI/MTLO writes, and is the single arbiter of HI/LO updates.

---
 rtl/ex_muldiv_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative multiply/divide sequencer for the EX stage.
// Runs MULT/MULTU/DIV/DIVU one bit per cycle, owns HI/LO, and arbitrates
// MTHI/MTLO writes against mul/div results.
//
// Optional build macro: EX_MULDIV_EARLY_OUT_EN. When defined, a multiply
// finishes as soon as the remaining multiplier magnitude is zero.
//
// Ports:
//   clk, rst_n        pipeline clock, synchronous active-low reset
//   start, op         issue request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   flush             squash the current operation
//   hi_we, lo_we      MTHI/MTLO write enables, wdata is the write data
//   stall             combinational freeze request to IF/ID/EX
//   busy              registered, high in PREP/RUN/FIX
//   done              one-cycle pulse after a HI/LO result write
//   hi, lo            HI/LO registers
//
// state | meaning
// IDLE  | waiting for start
// PREP  | operand magnitudes, result signs, divide-by-zero detect
// RUN   | one shift-add or restoring-divide step per cycle
// FIX   | sign fix-up and HI/LO write
// DONE  | done pulse; may accept a back-to-back start
module ex_muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

`ifdef EX_MULDIV_EARLY_OUT_EN
   localparam bit EarlyOut = 1'b1;
`else
   localparam bit EarlyOut = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_e;

   state_e               state_q, state_d;
   logic                 busy_q, done_q;
   logic [1:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

   logic                 accept, is_div, b_zero, signed_op;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [CNT_W-1:0]     eo_shamt;
   logic [2*WIDTH-1:0]   acc_neg;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign accept    = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign is_div    = op_q[1];
   assign b_zero    = (b_q == '0);
   assign signed_op = ~op_q[0];
   assign a_neg     = signed_op & a_q[WIDTH-1];
   assign b_neg     = signed_op & b_q[WIDTH-1];
   // The most negative value maps onto itself, which is the correct
   // unsigned magnitude.
   assign a_mag     = a_neg ? (-a_q) : a_q;
   assign b_mag     = b_neg ? (-b_q) : b_q;

   // Multiply: add into the upper half, then shift the whole accumulator
   // right; after WIDTH steps the product sits in acc_q.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, opnd_q} : '0);
   // Divide: acc_q holds {remainder, dividend/quotient}.
   assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift - {1'b0, opnd_q};
   // After k steps the partial product is scaled by 2^(WIDTH-k).
   assign eo_shamt  = CNT_W'(WIDTH) - cnt_q;
   assign acc_neg   = -acc_q;
   assign quo_fix   = neg_lo_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
   assign rem_fix   = neg_hi_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == S_PREP) | (state_d == S_RUN) | (state_d == S_FIX);
         done_q  <= (state_d == S_DONE);
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_PREP;
         S_PREP: begin
            if (flush)                                state_d = S_IDLE;
            else if (b_zero && (is_div || EarlyOut))  state_d = S_FIX;
            else                                      state_d = S_RUN;
         end
         S_RUN: begin
            if (flush)                                           state_d = S_IDLE;
            else if (EarlyOut && !is_div && (mplier_q == '0))    state_d = S_FIX;
            else if (cnt_q == CNT_W'(WIDTH - 1))                 state_d = S_FIX;
         end
         S_FIX:  state_d = flush ? S_IDLE : S_DONE;
         S_DONE: state_d = accept ? S_PREP : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      stall = accept | busy_q;
      busy  = busy_q;
      done  = done_q;
      hi    = hi_q;
      lo    = lo_q;
   end

   // datapath next-state
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      opnd_d   = opnd_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      if (accept) begin
         op_d = op;
         a_d  = src_a;
         b_d  = src_b;
      end

      // FIX is always busy, so MTHI/MTLO never collide with a result write.
      if (!busy_q) begin
         if (hi_we) hi_d = wdata;
         if (lo_we) lo_d = wdata;
      end

      unique case (state_q)
         S_PREP: begin
            cnt_d = '0;
            if (!is_div) begin
               acc_d    = '0;
               opnd_d   = a_mag;
               mplier_d = b_mag;
               neg_lo_d = a_neg ^ b_neg;
               neg_hi_d = a_neg ^ b_neg;
            end else if (b_zero) begin
               // quotient all-ones, remainder is the raw dividend
               acc_d    = {a_q, {WIDTH{1'b1}}};
               opnd_d   = '0;
               mplier_d = '0;
               neg_lo_d = 1'b0;
               neg_hi_d = 1'b0;
            end else begin
               acc_d    = {{WIDTH{1'b0}}, a_mag};
               opnd_d   = b_mag;
               mplier_d = '0;
               neg_lo_d = a_neg ^ b_neg;
               neg_hi_d = a_neg;
            end
         end
         S_RUN: begin
            if (!is_div) begin
               if (EarlyOut && (mplier_q == '0)) begin
                  acc_d = acc_q >> eo_shamt;
               end else begin
                  acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
                  mplier_d = mplier_q >> 1;
                  cnt_d    = cnt_q + CNT_W'(1);
               end
            end else begin
               if (!div_diff[WIDTH])
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FIX: begin
            if (!flush) begin
               if (!is_div) begin
                  {hi_d, lo_d} = neg_lo_q ? acc_neg : acc_q;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end
         end
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd_q   <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opnd_q   <= opnd_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed vectors, expected results queued at issue
// time and compared by a monitor whenever done pulses.
module tb_ex_muldiv_ctrl;

`ifdef EX_MULDIV_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, flush, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] src_a, src_b, wdata;
   logic        stall, busy, done;
   logic [31:0] hi, lo;

   ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got hi=%h lo=%h with nothing expected (cycle %0d)", hi, lo, cyc);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
            chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   // edges from start sample to HI/LO write
   function automatic int op_lat(input logic [1:0] o, input logic [31:0] b);
      logic [31:0] m;
      int msb;
      if (o[1]) return (b == 32'd0) ? 2 : 34;
      if (!EO) return 34;
      m = (!o[0] && b[31]) ? -b : b;
      if (m == 32'd0) return 2;
      msb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) msb = i;
      return (msb + 4 > 34) ? 34 : msb + 4;
   endfunction

   task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int lat;
      lat = op_lat(o, b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      sb.push_back('{eh, el, cyc + 1 + lat, name});
      @(negedge clk);
      start = 1'b0;
      repeat (lat + 2) @(negedge clk);
      chk({name, "_drained"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int e0;
      logic stall_ok;

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);

      // MULTU max*max with stall window
      @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
      e0 = cyc + 1;
      sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, e0 + 34, "multu_max"});
      #1;
      stall_ok = stall;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (stall !== 1'b1) stall_ok = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("multu_stall_window", 64'(stall_ok), 64'd1);
      chk("multu_done_stall_low", 64'(stall), 64'd0);
      repeat (2) @(negedge clk);
      chk("multu_max_drained", 64'(sb.size()), 64'd0);

      issue("mult_m7x3",    2'b00, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      issue("div_m7d2",     2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue("divu_100d0",   2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
      issue("div_min_dm1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      issue("div_m5d0",     2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
      issue("divu_maxd1",   2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF);
      issue("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
      issue("mult_m1xm1",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1);
      issue("divu_7d9",     2'b11, 32'd7,         32'd9,         32'd7,         32'd0);
      issue("div_7dm2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      issue("multu_x0",     2'b01, 32'h1234_5678, 32'd0,         32'd0,         32'd0);

      // MTHI / MTLO preload
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h11;
      #1;
      chk("mthi_no_stall", 64'(stall), 64'd0);
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mthi_hi", 64'(hi), 64'h11);
      chk("mtlo_lo", 64'(lo), 64'h22);

      // flush coincident with start in IDLE blocks acceptance
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b11; src_a = 32'd10; src_b = 32'd3;
      #1;
      chk("flush_start_stall", 64'(stall), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", 64'(busy), 64'd0);

      // flush mid-RUN: no write, no done
      @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'd10; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      chk("flush_hi_kept", 64'(hi), 64'h11);
      chk("flush_lo_kept", 64'(lo), 64'h22);

      // back-to-back issue from DONE, with an ignored MTLO while busy
      @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd2;
      e0 = cyc + 1;
      sb.push_back('{32'd1, 32'd4, e0 + 34, "b2b_divu_9d2"});
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      lo_we = 1'b1; wdata = 32'hDEAD;
      @(negedge clk);
      lo_we = 1'b0;
      chk("lo_we_busy_ignored", 64'(lo), 64'h22);
      for (int k = 0; k < 60 && cyc < e0 + 34; k++) @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3;
      sb.push_back('{32'd0, 32'd6, cyc + 1 + op_lat(2'b01, 32'd3), "b2b_multu_2x3"});
      #1;
      chk("b2b_stall", 64'(stall), 64'd1);
      @(negedge clk);
      start = 1'b0;
      repeat (op_lat(2'b01, 32'd3) + 2) @(negedge clk);
      chk("b2b_drained", 64'(sb.size()), 64'd0);

      // MTLO coincident with start is performed, then overwritten
      @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd3; lo_we = 1'b1; wdata = 32'h55;
      sb.push_back('{32'd0, 32'd15, cyc + 1 + op_lat(2'b01, 32'd3), "multu_5x3"});
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      chk("mtlo_with_start", 64'(lo), 64'h55);
      repeat (op_lat(2'b01, 32'd3) + 2) @(negedge clk);
      chk("multu_5x3_drained", 64'(sb.size()), 64'd0);

      // reset during RUN
      @(negedge clk);
      start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'h0000_0F09;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_run_hi", 64'(hi), 64'd0);
      chk("rst_run_lo", 64'(lo), 64'd0);
      chk("rst_run_busy", 64'(busy), 64'd0);
      chk("rst_run_stall", 64'(stall), 64'd0);
      repeat (40) @(negedge clk);
      chk("rst_run_done_low", 64'(done), 64'd0);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
